// File: rtl/pulse_classifier_pkg.sv
// Shared encodings for the pulse classifier: symbol codes and FSM states.
package pulse_classifier_pkg;

  // Symbol codes reported on the symbol output.
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_GAP  = 2'b11;

  // Run-tracking states: waiting for a pulse, inside a high run,
  // inside a low run, or parked after an over-long high run.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

endpackage

// File: rtl/pulse_classifier.sv
// Measures high/low run lengths on a serial line and classifies each
// completed run as DOT, DASH or GAP, with a strobe for over-long highs.
//
// Output handshake: symbol_valid is a one-cycle strobe with no back-pressure;
// symbol is meaningful in the cycle symbol_valid is high and otherwise holds
// the last reported code. error is a separate one-cycle strobe and is never
// high in the same cycle as symbol_valid.
//
// The FSM state and run counter are internal signals named state and
// run_len so checkers can observe them directly.
module pulse_classifier
  import pulse_classifier_pkg::*;
#(
  parameter int SHORT_MAX = 4,
  parameter int LONG_MAX  = 12,
  parameter int GAP_MIN   = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [1:0] symbol,
  output logic       symbol_valid,
  output logic       error
);

  // Thresholds at counter width so every comparison is width-matched.
  localparam logic [CNT_WIDTH-1:0] SHORT_LIMIT = CNT_WIDTH'(SHORT_MAX);
  localparam logic [CNT_WIDTH-1:0] LONG_LIMIT  = CNT_WIDTH'(LONG_MAX);
  // The GAP fires when the current sample would be the GAP_MIN-th low.
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(GAP_MIN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = '0;

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] run_len, next_run_len;
  logic [1:0]           next_symbol;
  logic                 next_valid;
  logic                 next_error;

  // State, run counter and registered outputs; reset discards any partial run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      run_len      <= CNT_ZERO;
      symbol       <= SYM_NONE;
      symbol_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= next_state;
      run_len      <= next_run_len;
      symbol       <= next_symbol;
      symbol_valid <= next_valid;
      error        <= next_error;
    end
  end

  // Next state, run length and strobes from the current sample of in.
  always_comb begin
    next_state   = state;
    next_run_len = run_len;
    next_symbol  = symbol;
    next_valid   = 1'b0;
    next_error   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in) begin
          next_state   = ST_HIGH;
          next_run_len = CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (in) begin
          if (run_len == LONG_LIMIT) begin
            next_error = 1'b1;
            next_state = ST_ERR;
          end else begin
            next_run_len = run_len + CNT_ONE;
          end
        end else begin
          // First low sample closes the high run; classify its length.
          next_symbol  = (run_len <= SHORT_LIMIT) ? SYM_DOT : SYM_DASH;
          next_valid   = 1'b1;
          next_state   = ST_LOW;
          next_run_len = CNT_ONE;
        end
      end

      ST_LOW: begin
        if (in) begin
          // Short low run between pulses: intra-character space, no strobe.
          next_state   = ST_HIGH;
          next_run_len = CNT_ONE;
        end else if (run_len == GAP_LAST) begin
          next_symbol  = SYM_GAP;
          next_valid   = 1'b1;
          next_state   = ST_IDLE;
          next_run_len = CNT_ZERO;
        end else begin
          next_run_len = run_len + CNT_ONE;
        end
      end

      ST_ERR: begin
        // Stay silent until the line drops; the trailing low is not a GAP.
        if (!in) begin
          next_state   = ST_IDLE;
          next_run_len = CNT_ZERO;
        end
      end

      default: begin
        next_state   = ST_IDLE;
        next_run_len = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_classifier.sv
// Directed bench for pulse_classifier: expected strobes (edge number, kind,
// symbol) are queued ahead of the stimulus and popped by a negedge monitor.
module tb_pulse_classifier;
  import pulse_classifier_pkg::*;

  localparam int W = 19; // {edge[15:0], is_error, symbol[1:0]}

  logic       clk;
  logic       reset;
  logic       in;
  logic [1:0] symbol;
  logic       symbol_valid;
  logic       error;

  int         cyc;
  int         checks;
  int         errors;
  logic [W-1:0] exp_q[$];
  logic [1:0] hold_sym;
  logic       prev_valid;

  pulse_classifier #(
    .SHORT_MAX(4),
    .LONG_MAX (12),
    .GAP_MIN  (8),
    .CNT_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .symbol      (symbol),
    .symbol_valid(symbol_valid),
    .error       (error)
  );

  // Clock and rising-edge counter; edge k makes cyc == k.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int e, input logic is_err, input logic [1:0] s);
    logic [15:0] e16;
    e16 = e[15:0];
    exp_q.push_back({e16, is_err, s});
  endtask

  // Drive n samples of lvl; called and returns just after a falling edge.
  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      in = lvl;
      @(negedge clk);
    end
  endtask

  // Monitor: pop and compare on every strobe, check hold/exclusivity rules.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs", {29'd0, symbol, symbol_valid, error}, 32'd0);
      hold_sym   = SYM_NONE;
      prev_valid = 1'b0;
    end else begin
      check("valid_error_exclusive", {31'd0, symbol_valid & error}, 32'd0);
      if (symbol_valid) check("no_back_to_back", {31'd0, prev_valid}, 32'd0);
      if (symbol_valid || error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {13'd0, cyc[15:0], error, symbol}, 32'd0);
        end else begin
          logic [W-1:0] exp_e;
          logic [W-1:0] act_e;
          exp_e = exp_q.pop_front();
          act_e = {cyc[15:0], error, (symbol_valid ? symbol : SYM_NONE)};
          check("strobe", 32'(act_e), 32'(exp_e));
          if (!exp_e[2]) hold_sym = exp_e[1:0];
        end
      end else begin
        check("symbol_hold", {30'd0, symbol}, {30'd0, hold_sym});
      end
      prev_valid = symbol_valid;
    end
  end

  initial begin
    int e0;
    checks   = 0;
    errors   = 0;
    hold_sym = SYM_NONE;
    prev_valid = 1'b0;
    reset    = 1'b1;
    in       = 1'b0;

    // Reset behaviour: async assert in the middle of a high run.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {29'd0, symbol, symbol_valid, error}, 32'd0);
    check("async_reset_state", 32'(dut.state), 32'(ST_IDLE));
    check("async_reset_run_len", 32'(dut.run_len), 32'd0);
    @(negedge clk);
    in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 20);

    // DOT then GAP: 4 high, 8 low.
    e0 = cyc + 1;
    push(e0 + 4, 1'b0, SYM_DOT);
    push(e0 + 11, 1'b0, SYM_GAP);
    drive(1'b1, 4);
    drive(1'b0, 8);
    drive(1'b0, 3);

    // DASH boundaries: 5 high / 3 low / 12 high / 8 low (GAP only at the end).
    e0 = cyc + 1;
    push(e0 + 5, 1'b0, SYM_DASH);
    push(e0 + 20, 1'b0, SYM_DASH);
    push(e0 + 27, 1'b0, SYM_GAP);
    drive(1'b1, 5);
    drive(1'b0, 3);
    drive(1'b1, 12);
    drive(1'b0, 8);

    // DOT boundary: single-cycle pulse.
    e0 = cyc + 1;
    push(e0 + 1, 1'b0, SYM_DOT);
    push(e0 + 8, 1'b0, SYM_GAP);
    drive(1'b1, 1);
    drive(1'b0, 8);

    // GAP_MIN-1 low run is only a space: 2 high / 7 low / 2 high / 8 low.
    e0 = cyc + 1;
    push(e0 + 2, 1'b0, SYM_DOT);
    push(e0 + 11, 1'b0, SYM_DOT);
    push(e0 + 18, 1'b0, SYM_GAP);
    drive(1'b1, 2);
    drive(1'b0, 7);
    drive(1'b1, 2);
    drive(1'b0, 8);

    // Stuck high: error after 13th high sample, nothing else.
    e0 = cyc + 1;
    push(e0 + 12, 1'b1, SYM_NONE);
    drive(1'b1, 20);
    check("err_state_held", 32'(dut.state), 32'(ST_ERR));
    drive(1'b0, 10);
    check("idle_after_err", 32'(dut.state), 32'(ST_IDLE));

    // Sequence: DOT, DASH, DOT with 2-cycle spaces, then GAP.
    e0 = cyc + 1;
    push(e0 + 2, 1'b0, SYM_DOT);
    push(e0 + 10, 1'b0, SYM_DASH);
    push(e0 + 15, 1'b0, SYM_DOT);
    push(e0 + 22, 1'b0, SYM_GAP);
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b1, 6);
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 8);

    drive(1'b0, 4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
